fp_adder_arbiter: RTL

FP_ADDER_ARBITER -- requirements
Module: fp_adder_arbiter

---
 rtl/fp_adder_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fp_adder_arbiter.sv
// Shares one single-precision FP adder among N_REQ requesters, one operation in flight.
// Round-robin by default; define FP_ADDER_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest).
module fp_adder_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  input  logic [N_REQ-1:0]     req_stb,
  output logic [N_REQ-1:0]     req_ack,
  output logic [31:0]          rsp_z,
  output logic [N_REQ-1:0]     rsp_stb,
  input  logic [N_REQ-1:0]     rsp_ack,
  output logic [31:0]          adder_a,
  output logic [31:0]          adder_b,
  output logic                 adder_ab_stb,
  input  logic                 adder_ab_ack,
  input  logic [31:0]          adder_z,
  input  logic                 adder_z_stb,
  output logic                 adder_z_ack,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_Z, RETURN} state_t;

  state_t               state, state_nx;
  logic [IDW-1:0]       ptr, ptr_nx, win, grant_nx;
  logic                 any_req;
  logic [2**IDW-1:0]    stb_pad, ack_pad;
  logic [31:0]          sel_a, sel_b, a_nx, b_nx, z_nx;
  logic [N_REQ-1:0]     req_ack_nx, rsp_stb_nx;
  logic                 ab_stb_nx, z_ack_nx;

  // Padding to 2**IDW lets an IDW-bit index address the request bits directly.
  assign stb_pad = (2**IDW)'(req_stb);
  assign ack_pad = (2**IDW)'(rsp_ack);

`ifdef FP_ADDER_ARB_FIXED_PRIO_EN
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      if (stb_pad[IDW'(k-1)]) begin
        win     = IDW'(k-1);
        any_req = 1'b1;
      end
    end
  end
`else
  logic [IDW:0] cand;

  // Scan offsets from highest to lowest so the last hit is the first index at or after ptr.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      cand = {1'b0, ptr} + (IDW+1)'(k-1);
      if (cand >= (IDW+1)'(N_REQ))
        cand = cand - (IDW+1)'(N_REQ);
      if (stb_pad[cand[IDW-1:0]]) begin
        win     = cand[IDW-1:0];
        any_req = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win == IDW'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      grant_id     <= '0;
      req_ack      <= '0;
      rsp_stb      <= '0;
      rsp_z        <= '0;
      adder_a      <= '0;
      adder_b      <= '0;
      adder_ab_stb <= 1'b0;
      adder_z_ack  <= 1'b0;
    end else begin
      state        <= state_nx;
      ptr          <= ptr_nx;
      grant_id     <= grant_nx;
      req_ack      <= req_ack_nx;
      rsp_stb      <= rsp_stb_nx;
      rsp_z        <= z_nx;
      adder_a      <= a_nx;
      adder_b      <= b_nx;
      adder_ab_stb <= ab_stb_nx;
      adder_z_ack  <= z_ack_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req)                    state_nx = ISSUE;
      ISSUE:   if (adder_ab_stb && adder_ab_ack) state_nx = WAIT_Z;
      WAIT_Z:  if (adder_z_stb && adder_z_ack)   state_nx = RETURN;
      RETURN:  if (ack_pad[grant_id])          state_nx = IDLE;
      default:                                 state_nx = IDLE;
    endcase
  end

  always_comb begin
    ptr_nx     = ptr;
    grant_nx   = grant_id;
    req_ack_nx = '0;
    rsp_stb_nx = rsp_stb;
    z_nx       = rsp_z;
    a_nx       = adder_a;
    b_nx       = adder_b;
    ab_stb_nx  = adder_ab_stb;
    z_ack_nx   = adder_z_ack;
    case (state)
      IDLE: if (any_req) begin
        grant_nx   = win;
        a_nx       = sel_a;
        b_nx       = sel_b;
        req_ack_nx = N_REQ'(1) << win;
        ab_stb_nx  = 1'b1;
      end
      ISSUE: if (adder_ab_stb && adder_ab_ack) begin
        ab_stb_nx = 1'b0;
        z_ack_nx  = 1'b1;
      end
      WAIT_Z: if (adder_z_stb && adder_z_ack) begin
        z_nx       = adder_z;
        z_ack_nx   = 1'b0;
        rsp_stb_nx = N_REQ'(1) << grant_id;
      end
      RETURN: if (ack_pad[grant_id]) begin
        rsp_stb_nx = '0;
        ptr_nx     = (grant_id == IDW'(N_REQ-1)) ? '0 : grant_id + 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
